pcm_pdm_tx: RTL and testbench

//   Audio playback end of the PCM audio path: converts 16-bit two's-complement PCM samples

---
 rtl/pcm_pdm_tx.sv | 164 ++++++++++++++++
 tb/tb_pcm_pdm_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_pdm_tx.sv
// pcm_pdm_tx: a sample FIFO feeds a first-order sigma-delta modulator that drives a 1-bit PDM stream,
// and the block also controls the amplifier shutdown pin. Define PDM_TX_DITHER_EN to add LFSR carry-in dither.
module pcm_pdm_tx #(
    parameter int FI         = 100000000,
    parameter int FBIT       = 3072000,
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pcm_data,
    input  logic        pcm_valid,
    output logic        pcm_ready,
    output logic        pdm_out,
    output logic        aud_sd,
    output logic        underrun,
    output logic        led,
    output logic [1:0]  dbg_state
);
    localparam int DIV_RAW = FI / FBIT;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW      = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [IW-1:0] bit_idx;
    logic [15:0]   acc;
    logic [15:0]   cur_sample;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          cin;
    logic          tick;
    logic          boundary;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          go_run;
    logic [16:0]   sum;

    // Handshake: a word transfers on a rising edge where pcm_valid && pcm_ready;
    // pcm_ready never depends on pcm_valid.
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign pcm_ready  = !fifo_full && (state != IDLE);
    assign dbg_state  = state;

    assign tick     = ((state == PRIME) || (state == RUN)) && (div_cnt == '0);
    assign boundary = tick && (bit_idx == IW'(OSR - 1));
    assign go_run   = (state == PRIME) && boundary && (count >= CW'(2));
    assign push     = pcm_valid && pcm_ready && enable;
    // Pop decisions use the registered count, so a same-cycle push never bypasses an empty FIFO.
    assign pop      = enable && boundary && !fifo_empty && ((state == RUN) || go_run);
    assign sum      = {1'b0, acc} + {1'b0, cur_sample ^ 16'h8000} + {16'd0, cin};

`ifdef PDM_TX_DITHER_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr <= 16'hACE1;
        else if (!enable || state == IDLE)
            lfsr <= 16'hACE1;
        else if (tick)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign cin = lfsr[0];
`else
    assign cin = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= pcm_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (!enable || state == IDLE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            div_cnt    <= DW'(DIV - 1);
            bit_idx    <= '0;
            acc        <= '0;
            cur_sample <= '0;
            pdm_out    <= 1'b0;
            aud_sd     <= 1'b0;
            underrun   <= 1'b0;
            led        <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (!enable) begin
                // Abort from any state: nothing of a partial sample survives.
                state      <= IDLE;
                div_cnt    <= DW'(DIV - 1);
                bit_idx    <= '0;
                acc        <= '0;
                cur_sample <= '0;
                pdm_out    <= 1'b0;
                aud_sd     <= 1'b0;
                led        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= PRIME;
                        aud_sd <= 1'b1;
                    end
                    PRIME, RUN: begin
                        if (tick) begin
                            div_cnt <= DW'(DIV - 1);
                            acc     <= sum[15:0];
                            pdm_out <= sum[16];
                            bit_idx <= (bit_idx == IW'(OSR - 1)) ? '0 : bit_idx + IW'(1);
                        end else begin
                            div_cnt <= div_cnt - DW'(1);
                        end
                        if (boundary) begin
                            if (state == RUN) begin
                                if (fifo_empty) begin
                                    cur_sample <= 16'h0000;
                                    underrun   <= 1'b1;
                                end else begin
                                    cur_sample <= mem[rd_ptr];
                                end
                            end else if (go_run) begin
                                state      <= RUN;
                                led        <= 1'b1;
                                cur_sample <= mem[rd_ptr];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pcm_pdm_tx.sv
// Bench for pcm_pdm_tx: reset, tick timing, prime/run entry, per-slot ones counts for a table of
// samples, backpressure, underrun pulses, abort and re-enable.
module tb_pcm_pdm_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] pcm_data;
    logic        pcm_valid;
    logic        pcm_ready;
    logic        pdm_out;
    logic        aud_sd;
    logic        underrun;
    logic        led;
    logic [1:0]  dbg_state;

    int          cyc;
    int          n_cmp;
    int          n_bad;
    int          base;
    int          ones;
    logic        first;
    logic        ur;
    logic [15:0] drv_q[$];
    logic [6:0]  exp_q[$];

    typedef struct {
        logic [15:0] sample;
        int          ones;
        logic        first;
        logic        urun;
        logic        feed;
    } slot_vec_t;

    slot_vec_t vecs [11];

    pcm_pdm_tx dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .pcm_data  (pcm_data),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .pdm_out   (pdm_out),
        .aud_sd    (aud_sd),
        .underrun  (underrun),
        .led       (led),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: one clock, retiring the presented word if it was accepted on that edge.
    task automatic next_cycle();
        logic xfer;
        xfer = pcm_valid && pcm_ready;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (xfer && drv_q.size() > 0)
            void'(drv_q.pop_front());
        if (drv_q.size() > 0) begin
            pcm_valid = 1'b1;
            pcm_data  = drv_q[0];
        end else begin
            pcm_valid = 1'b0;
            pcm_data  = 16'h0000;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target)
            next_cycle();
    endtask

    // Slot m holds the sample popped at tick 64*(m+1); its bits are ticks 64*(m+1)+1 .. 64*(m+2).
    task automatic collect_slot(input int b, input int m, output int n1, output logic f, output logic u);
        n1 = 0;
        f  = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            run_to(b + 32 * (64 * (m + 1) + k));
            if (pdm_out)
                n1++;
            if (k == 1)
                f = pdm_out;
        end
        u = underrun;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = -1;

        vecs[0]  = '{16'h0000, 32, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{16'h0000, 32, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{16'h0000, 32, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{16'h0000, 32, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{16'h7FFF, 63, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{16'h8000,  0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{16'h4000, 48, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{16'hC000, 16, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{16'h0001, 33, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{16'hFFFF, 31, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{16'h0000, 32, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].feed)
                drv_q.push_back(vecs[i].sample);
            exp_q.push_back(7'(vecs[i].ones));
        end

        reset     = 1'b0;
        enable    = 1'b1;
        pcm_valid = 1'b1;
        pcm_data  = drv_q[0];
        repeat (3) @(negedge clk);
        check("rst_pdm_out", pdm_out, 0);
        check("rst_aud_sd", aud_sd, 0);
        check("rst_led", led, 0);
        check("rst_pcm_ready", pcm_ready, 0);
        check("rst_underrun", underrun, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b1;

        run_to(0);
        check("prime_ready", pcm_ready, 1);
        check("prime_aud_sd", aud_sd, 1);
        check("prime_led", led, 0);
        check("prime_state", dbg_state, 1);
        run_to(4);
        check("full_ready", pcm_ready, 0);
        check("accepted_words", drv_q.size(), 6);

        run_to(31);
        check("pdm_before_tick1", pdm_out, 0);
        run_to(32);
        check("pdm_tick1", pdm_out, 0);
        run_to(64);
        check("pdm_tick2", pdm_out, 1);
        run_to(95);
        check("pdm_hold", pdm_out, 1);
        run_to(96);
        check("pdm_tick3", pdm_out, 0);

        run_to(2047);
        check("pre_run_led", led, 0);
        check("pre_run_ready", pcm_ready, 0);
        run_to(2048);
        check("run_led", led, 1);
        check("run_state", dbg_state, 2);
        check("run_ready_after_pop", pcm_ready, 1);
        check("run_entry_underrun", underrun, 0);
        run_to(2049);
        check("ready_one_transfer", pcm_ready, 0);

        for (int m = 0; m < 11; m++) begin
            collect_slot(0, m, ones, first, ur);
            check($sformatf("slot%0d_ones", m), ones, exp_q.pop_front());
            check($sformatf("slot%0d_first", m), first, vecs[m].first);
            check($sformatf("slot%0d_underrun", m), ur, vecs[m].urun);
            if (vecs[m].urun) begin
                next_cycle();
                check($sformatf("slot%0d_underrun_pulse", m), underrun, 0);
                check($sformatf("slot%0d_led", m), led, 1);
            end
        end

        // Two words parked in the FIFO, then an abort mid-slot.
        drv_q.push_back(16'h1234);
        drv_q.push_back(16'h5678);
        run_to(32 * 785 + 2);
        check("pre_abort_pdm", pdm_out, 1);
        check("pre_abort_words_taken", drv_q.size(), 0);
        enable = 1'b0;
        next_cycle();
        check("abort_state", dbg_state, 0);
        check("abort_aud_sd", aud_sd, 0);
        check("abort_pdm", pdm_out, 0);
        check("abort_ready", pcm_ready, 0);
        check("abort_led", led, 0);
        repeat (3) next_cycle();
        check("idle_ready", pcm_ready, 0);
        enable = 1'b1;
        next_cycle();
        base = cyc;
        check("reen_state", dbg_state, 1);
        check("reen_ready", pcm_ready, 1);
        check("reen_aud_sd", aud_sd, 1);

        drv_q.push_back(16'h7FFF);
        run_to(base + 32);
        check("reen_pdm_tick1", pdm_out, 0);
        run_to(base + 64);
        check("reen_pdm_tick2", pdm_out, 1);
        run_to(base + 2048);
        check("reen_one_word_stays_prime", dbg_state, 1);
        check("reen_prime_led", led, 0);
        check("reen_prime_no_underrun", underrun, 0);
        drv_q.push_back(16'h8000);
        run_to(base + 4096);
        check("reen_run_state", dbg_state, 2);
        check("reen_run_led", led, 1);
        exp_q.push_back(7'd63);
        collect_slot(base, 1, ones, first, ur);
        check("reen_slot_ones", ones, exp_q.pop_front());
        check("reen_slot_first", first, 0);
        check("reen_slot_underrun", ur, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
